// File: rtl/bht_pkg.sv
// Shared types, constants and index helper for the gshare branch history table.
package bht_pkg;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_WNT = 2'b01;
  localparam bht_cnt_t CNT_MAX = 2'b11;

  // Widest PC / history the shared update record can carry; instances zero-extend into it.
  localparam int unsigned BHT_PC_W    = 64;
  localparam int unsigned BHT_GHIST_W = 16;

  typedef enum logic {
    BHT_INIT,
    BHT_IDLE
  } bht_state_e;

  typedef struct packed {
    logic                   valid;
    logic [BHT_PC_W-1:0]    pc;
    logic [BHT_GHIST_W-1:0] ghist;
    logic                   taken;
    logic                   mispredict;
  } bht_update_t;

  // Row = PC bits above the halfword and slot offset, XORed with the history, cut to idx_w bits.
  function automatic logic [BHT_GHIST_W-1:0] bht_row_idx(
    input logic [BHT_PC_W-1:0]    pc,
    input logic [BHT_GHIST_W-1:0] ghist,
    input int unsigned            ofs_w,
    input int unsigned            idx_w
  );
    logic [BHT_GHIST_W-1:0] mask;
    mask = (idx_w >= BHT_GHIST_W) ? '1
         : ((BHT_GHIST_W'(1) << idx_w) - BHT_GHIST_W'(1));
    return (BHT_GHIST_W'(pc >> (ofs_w + 1)) ^ ghist) & mask;
  endfunction

endpackage

// File: rtl/bht_ghist_predictor_if.sv
// Lookup, speculative-history and resolve signals between the frontend and the predictor.
interface bht_ghist_predictor_if #(
  parameter int unsigned VLEN            = 39,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned HIST_LEN        = 3
);
  logic                       flush_bp_i;
  logic [VLEN-1:0]            vpc_i;
  logic [INSTR_PER_FETCH-1:0] pred_valid_o;
  logic [INSTR_PER_FETCH-1:0] pred_taken_o;
  logic [HIST_LEN-1:0]        pred_ghist_o;
  logic                       spec_push_i;
  logic                       spec_taken_i;
  logic                       update_valid_i;
  logic [VLEN-1:0]            update_pc_i;
  logic [HIST_LEN-1:0]        update_ghist_i;
  logic                       update_taken_i;
  logic                       update_mispredict_i;
  logic                       init_busy_o;

  modport slave (
    input  flush_bp_i, vpc_i, spec_push_i, spec_taken_i,
           update_valid_i, update_pc_i, update_ghist_i, update_taken_i, update_mispredict_i,
    output pred_valid_o, pred_taken_o, pred_ghist_o, init_busy_o
  );

  modport master (
    output flush_bp_i, vpc_i, spec_push_i, spec_taken_i,
           update_valid_i, update_pc_i, update_ghist_i, update_taken_i, update_mispredict_i,
    input  pred_valid_o, pred_taken_o, pred_ghist_o, init_busy_o
  );
endinterface

// File: rtl/bht_ghr.sv
// Speculative global history register: clear beats mispredict restore, which beats a push.
module bht_ghr #(
  parameter int unsigned HIST_LEN = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                restore_i,
  input  logic [HIST_LEN-1:0] restore_ghist_i,
  input  logic                restore_taken_i,
  input  logic                push_i,
  input  logic                push_taken_i,
  output logic [HIST_LEN-1:0] ghr_o
);

  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic [HIST_LEN-1:0] restore_val, push_val;

  if (HIST_LEN == 1) begin : g_single
    assign restore_val = restore_taken_i;
    assign push_val    = push_taken_i;
  end else begin : g_shift
    assign restore_val = {restore_ghist_i[HIST_LEN-2:0], restore_taken_i};
    assign push_val    = {ghr_q[HIST_LEN-2:0], push_taken_i};
  end

  always_comb begin
    ghr_d = ghr_q;
    if (clear_i) begin
      ghr_d = '0;
    end else if (restore_i) begin
      ghr_d = restore_val;
    end else if (push_i) begin
      ghr_d = push_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/bht_ghist_predictor.sv
// Gshare branch predictor: per-slot 2-bit counters indexed by PC ^ GHR, self-initialising
// through a row sweep so the counter storage carries no reset.
module bht_ghist_predictor
  import bht_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 128,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned HIST_LEN        = 3,
  parameter int unsigned VLEN            = 39
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  bht_ghist_predictor_if.slave bp
);

  localparam int unsigned ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned IDX_W  = $clog2(ROWS);
  localparam int unsigned OFS_W  = $clog2(INSTR_PER_FETCH);
  localparam int unsigned SLOT_W = (OFS_W > 0) ? OFS_W : 1;

  if (HIST_LEN == 0 || HIST_LEN > IDX_W || HIST_LEN > BHT_GHIST_W || VLEN > BHT_PC_W ||
      NR_ENTRIES < 2 * INSTR_PER_FETCH || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0 ||
      (INSTR_PER_FETCH & (INSTR_PER_FETCH - 1)) != 0) begin : g_param_err
    $error("bht_ghist_predictor: illegal parameter combination");
  end

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] row_ptr_q, row_ptr_d;
  logic             busy;

  logic [HIST_LEN-1:0] ghr;
  bht_update_t         upd;
  logic [IDX_W-1:0]    lookup_row, upd_row;
  logic [SLOT_W-1:0]   upd_slot;
  logic                upd_we;
  bht_cnt_t            upd_old [INSTR_PER_FETCH];
  bht_cnt_t            upd_cur, upd_next;

  assign upd = '{valid:      bp.update_valid_i,
                 pc:         BHT_PC_W'(bp.update_pc_i),
                 ghist:      BHT_GHIST_W'(bp.update_ghist_i),
                 taken:      bp.update_taken_i,
                 mispredict: bp.update_mispredict_i};

  assign lookup_row = IDX_W'(bht_row_idx(BHT_PC_W'(bp.vpc_i), BHT_GHIST_W'(ghr), OFS_W, IDX_W));
  assign upd_row    = IDX_W'(bht_row_idx(upd.pc, upd.ghist, OFS_W, IDX_W));

  if (OFS_W > 0) begin : g_slot
    assign upd_slot = upd.pc[1 +: SLOT_W];
  end else begin : g_no_slot
    assign upd_slot = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BHT_INIT;
      row_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    case (state_q)
      BHT_INIT: begin
        row_ptr_d = row_ptr_q + IDX_W'(1);
        if (row_ptr_q == IDX_W'(ROWS - 1)) begin
          state_d = BHT_IDLE;
        end
      end
      default: ;
    endcase
    if (bp.flush_bp_i) begin
      state_d   = BHT_INIT;
      row_ptr_d = '0;
    end
  end

  assign busy   = (state_q == BHT_INIT);
  assign upd_we = upd.valid & ~busy;

  assign upd_cur = upd_old[upd_slot];

  always_comb begin
    upd_next = upd_cur;
    if (upd.taken && upd_cur != CNT_MAX) begin
      upd_next = upd_cur + bht_cnt_t'(1);
    end else if (!upd.taken && upd_cur != '0) begin
      upd_next = upd_cur - bht_cnt_t'(1);
    end
  end

  // One counter array per slot; reads are asynchronous so old data is seen on a same-row write.
  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot_mem
    bht_cnt_t cnt_q [ROWS];

    always_ff @(posedge clk_i) begin
      if (busy) begin
        cnt_q[row_ptr_q] <= CNT_WNT;
      end else if (upd_we && upd_slot == SLOT_W'(gi)) begin
        cnt_q[upd_row] <= upd_next;
      end
    end

    assign upd_old[gi]        = cnt_q[upd_row];
    assign bp.pred_taken_o[gi] = ~busy & cnt_q[lookup_row][1];
  end

  bht_ghr #(
    .HIST_LEN(HIST_LEN)
  ) u_ghr (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (busy | bp.flush_bp_i),
    .restore_i      (upd.valid & upd.mispredict),
    .restore_ghist_i(upd.ghist[HIST_LEN-1:0]),
    .restore_taken_i(upd.taken),
    .push_i         (bp.spec_push_i),
    .push_taken_i   (bp.spec_taken_i),
    .ghr_o          (ghr)
  );

  assign bp.pred_valid_o = busy ? '0 : '1;
  assign bp.pred_ghist_o = ghr;
  assign bp.init_busy_o  = busy;

endmodule

// File: tb/tb_bht_ghist_predictor.sv
// Directed bench for the gshare predictor; expectations queued at stimulus, popped at sampling.
module tb_bht_ghist_predictor;

  logic clk;
  logic rst_n;

  bht_ghist_predictor_if #(.VLEN(39), .INSTR_PER_FETCH(2), .HIST_LEN(3)) bus ();

  bht_ghist_predictor #(
    .NR_ENTRIES     (128),
    .INSTR_PER_FETCH(2),
    .HIST_LEN       (3),
    .VLEN           (39)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [38:0] PC_A = 39'h0_8000_0010;

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [38:0] pc, input logic [2:0] g, input logic t, input logic m);
    bus.update_valid_i      = 1'b1;
    bus.update_pc_i         = pc;
    bus.update_ghist_i      = g;
    bus.update_taken_i      = t;
    bus.update_mispredict_i = m;
    tick();
    bus.update_valid_i      = 1'b0;
    bus.update_mispredict_i = 1'b0;
  endtask

  task automatic push(input logic t);
    bus.spec_push_i  = 1'b1;
    bus.spec_taken_i = t;
    tick();
    bus.spec_push_i  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [38:0] pc, input logic [1:0] exp_taken);
    bus.vpc_i = pc;
    #1;
    sb_push(tag, 64'(exp_taken));
    sb_check(64'(bus.pred_taken_o));
  endtask

  // Counts rising edges until busy drops; an optional update is injected mid-sweep.
  task automatic count_busy(input string tag, input bit inject);
    int n;
    n = 0;
    while (bus.init_busy_o === 1'b1 && n < 200) begin
      if (inject && n == 40) begin
        bus.update_valid_i = 1'b1;
        bus.update_pc_i    = '0;
        bus.update_ghist_i = '0;
        bus.update_taken_i = 1'b1;
      end else begin
        bus.update_valid_i = 1'b0;
      end
      if (n == 10) begin
        sb_push({tag, "_valid_low"}, 64'd0);
        sb_check(64'(bus.pred_valid_o));
      end
      tick();
      n++;
    end
    bus.update_valid_i = 1'b0;
    sb_push(tag, 64'd64);
    sb_check(64'(n));
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.flush_bp_i          = 1'b0;
    bus.vpc_i               = '0;
    bus.spec_push_i         = 1'b0;
    bus.spec_taken_i        = 1'b0;
    bus.update_valid_i      = 1'b0;
    bus.update_pc_i         = '0;
    bus.update_ghist_i      = '0;
    bus.update_taken_i      = 1'b0;
    bus.update_mispredict_i = 1'b0;

    // Reset values
    #2;
    sb_push("rst_busy", 64'd1);   sb_check(64'(bus.init_busy_o));
    sb_push("rst_valid", 64'd0);  sb_check(64'(bus.pred_valid_o));
    sb_push("rst_taken", 64'd0);  sb_check(64'(bus.pred_taken_o));
    sb_push("rst_ghist", 64'd0);  sb_check(64'(bus.pred_ghist_o));
    tick();
    tick();
    rst_n = 1'b1;

    // 1. Initial sweep takes 64 cycles, then everything predicts not-taken
    count_busy("init_busy_cycles", 1'b0);
    sb_push("idle_valid", 64'd3); sb_check(64'(bus.pred_valid_o));
    sb_push("idle_ghist", 64'd0); sb_check(64'(bus.pred_ghist_o));
    for (int r = 0; r < 64; r++) begin
      look("init_row_nt", 39'(r << 2), 2'b00);
    end

    // 2. Training at PC_A (row 4, slot 0); first update also checks no bypass
    bus.vpc_i               = PC_A;
    bus.update_valid_i      = 1'b1;
    bus.update_pc_i         = PC_A;
    bus.update_ghist_i      = 3'b000;
    bus.update_taken_i      = 1'b1;
    bus.update_mispredict_i = 1'b0;
    #1;
    sb_push("no_bypass", 64'd0);  sb_check(64'(bus.pred_taken_o));
    tick();
    bus.update_valid_i = 1'b0;
    look("upd_visible", PC_A, 2'b01);
    upd(PC_A, 3'b000, 1'b1, 1'b0);
    upd(PC_A, 3'b000, 1'b1, 1'b0);
    look("three_taken", PC_A, 2'b01);
    upd(PC_A, 3'b000, 1'b1, 1'b0);
    look("sat_high", PC_A, 2'b01);
    upd(PC_A, 3'b000, 1'b0, 1'b0);
    look("one_nt_still_t", PC_A, 2'b01);
    upd(PC_A, 3'b000, 1'b0, 1'b0);
    look("back_nt", PC_A, 2'b00);
    upd(PC_A, 3'b000, 1'b0, 1'b0);
    upd(PC_A, 3'b000, 1'b0, 1'b0);
    upd(PC_A, 3'b000, 1'b1, 1'b0);
    look("sat_low", PC_A, 2'b00);
    upd(PC_A, 3'b000, 1'b1, 1'b0);
    look("rise_again", PC_A, 2'b01);

    // 3. Speculative pushes and mispredict restore
    push(1'b1);
    push(1'b1);
    push(1'b0);
    sb_push("push_110", 64'd6);  sb_check(64'(bus.pred_ghist_o));
    upd(39'h20, 3'b011, 1'b1, 1'b1);
    sb_push("restore_111", 64'd7);  sb_check(64'(bus.pred_ghist_o));

    // 4. Push and mispredict together: restore wins
    bus.spec_push_i  = 1'b1;
    bus.spec_taken_i = 1'b1;
    upd(39'h40, 3'b010, 1'b0, 1'b1);
    bus.spec_push_i  = 1'b0;
    sb_push("restore_beats_push", 64'd4);  sb_check(64'(bus.pred_ghist_o));

    // 5. History selects the row
    upd(39'h200, 3'b000, 1'b0, 1'b1);
    sb_push("ghr_zeroed", 64'd0);  sb_check(64'(bus.pred_ghist_o));
    upd(39'h30, 3'b000, 1'b1, 1'b0);
    upd(39'h30, 3'b000, 1'b1, 1'b0);
    look("ghr0_trained", 39'h30, 2'b01);
    push(1'b1);
    push(1'b0);
    push(1'b1);
    sb_push("ghr_101", 64'd5);  sb_check(64'(bus.pred_ghist_o));
    look("ghr101_other_row", 39'h30, 2'b00);

    // 6. Flush mid-sweep restarts it; updates during the sweep are dropped
    bus.flush_bp_i = 1'b1;
    tick();
    bus.flush_bp_i = 1'b0;
    sb_push("flush_busy", 64'd1);  sb_check(64'(bus.init_busy_o));
    sb_push("flush_ghist", 64'd0); sb_check(64'(bus.pred_ghist_o));
    repeat (19) tick();
    sb_push("mid_sweep_busy", 64'd1);  sb_check(64'(bus.init_busy_o));
    bus.flush_bp_i = 1'b1;
    tick();
    bus.flush_bp_i = 1'b0;
    count_busy("reflush_busy_cycles", 1'b1);
    sb_push("post_flush_valid", 64'd3);  sb_check(64'(bus.pred_valid_o));
    look("dropped_update", 39'h0, 2'b00);
    look("swept_row12", 39'h30, 2'b00);
    look("swept_pc_a", PC_A, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
